// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage.
//   stage_state_e : occupancy state of the two-entry skid stage
//   LANE_*        : lane indices of the default M-stage layout
//   occ_of()      : occupancy count encoded by a state
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam int LANE_ALURES = 0;
    localparam int LANE_HL     = 1;
    localparam int LANE_PC     = 2;
    localparam int LANE_INSTR  = 3;
    localparam int LANE_FWDRT  = 4;

    function automatic logic [1:0] occ_of(input stage_state_e s);
        return logic'(s == ONE) ? 2'd1 : (s == TWO) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One LANES*DATA_W storage entry of the skid stage.
// Ports:
//   clk_i, reset_i  clock and async active-high reset
//   load_i          capture load_data_i
//   load_data_i     data to capture
//   clear_i         clear the entry; wins over load_i
//   keep_mask_i     lanes that take keep_data_i instead of zero on clear
//   keep_data_i     source for the kept lanes on clear
//   data_o          registered contents
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int LANES  = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_i,
    input  logic [LANES*DATA_W-1:0]  load_data_i,
    input  logic                     clear_i,
    input  logic [LANES-1:0]         keep_mask_i,
    input  logic [LANES*DATA_W-1:0]  keep_data_i,
    output logic [LANES*DATA_W-1:0]  data_o
);

    logic [LANES*DATA_W-1:0] data_q;
    logic [LANES*DATA_W-1:0] data_d;
    logic [LANES*DATA_W-1:0] keep_bits;

    // Widen the per-lane mask to a per-bit mask.
    always_comb begin
        keep_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            keep_bits[i*DATA_W +: DATA_W] = {DATA_W{keep_mask_i[i]}};
        end
    end

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = keep_data_i & keep_bits;
        end else if (load_i) begin
            data_d = load_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with a two-entry skid buffer between two stages.
// in_ready_o depends on registered state only, so downstream stalls never
// reach upstream combinationally. Flush turns the stage into a bubble and
// can keep the PC lane so later stages can still report EPC.
//
// state | meaning
// EMPTY | no beat held, out_data_o is zero (apart from a kept PC lane)
// ONE   | one beat in main, skid empty
// TWO   | head beat in main, next beat in skid, upstream stalled
//
// Ports:
//   clk_i, reset_i            clock and async active-high reset
//   in_valid_i/in_ready_o     upstream handshake
//   in_data_i                 lane i at [i*DATA_W +: DATA_W]
//   flush_i                   discard all held beats at the next edge
//   out_valid_o/out_ready_i   downstream handshake
//   out_data_o                head entry (main register)
//   occupancy_o               entries held: 0, 1 or 2
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int LANES            = 5,
    parameter int PC_LANE          = LANE_PC,   // must be < LANES
    parameter bit KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [LANES*DATA_W-1:0]  in_data_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LANES*DATA_W-1:0]  out_data_o,
    output logic [1:0]               occupancy_o
);

    localparam logic [LANES-1:0] PC_MASK =
        KEEP_PC_ON_FLUSH ? (LANES'(1) << PC_LANE) : '0;

    stage_state_e state_q, state_d;

    logic                    push, pop;
    logic [LANES*DATA_W-1:0] main_data, skid_data;
    logic                    main_load, main_clear;
    logic [LANES*DATA_W-1:0] main_load_data, main_keep_data;
    logic [LANES-1:0]        main_keep_mask;
    logic                    skid_load, skid_clear;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = TWO;
                    else if (!push && pop) state_d = EMPTY;
                end
                TWO:   if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output and slot-control logic
    always_comb begin
        in_ready_o     = (state_q != TWO);
        out_valid_o    = (state_q != EMPTY);
        occupancy_o    = occ_of(state_q);
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_keep_mask = '0;
        main_keep_data = main_data;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        // Only TWO refills main from skid; every other load takes in_data.
        main_load_data = (state_q == TWO) ? skid_data : in_data_i;
        if (flush_i) begin
            main_clear     = 1'b1;
            main_keep_mask = PC_MASK;
            // A beat arriving into an empty stage is dropped, but its PC is
            // the most recent one and is what a later EPC must see.
            if (state_q == EMPTY && push) begin
                main_keep_data = in_data_i;
            end
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: main_load = push;
                ONE: begin
                    main_load  = push & pop;
                    main_clear = ~push & pop;
                    skid_load  = push & ~pop;
                end
                TWO: begin
                    main_load  = pop;
                    skid_clear = pop;
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_main (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (main_load),
        .load_data_i (main_load_data),
        .clear_i     (main_clear),
        .keep_mask_i (main_keep_mask),
        .keep_data_i (main_keep_data),
        .data_o      (main_data)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_skid (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (skid_load),
        .load_data_i (in_data_i),
        .clear_i     (skid_clear),
        .keep_mask_i ('0),
        .keep_data_i ('0),
        .data_o      (skid_data)
    );

    assign out_data_o = main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int LN = 5;
    localparam int BW = DW * LN;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, out_ready, flush;
    logic [BW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    occupancy;

    logic          in_ready0, out_valid0;
    logic [BW-1:0] out_data0;
    logic [1:0]    occupancy0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .LANES(LN), .PC_LANE(LANE_PC), .KEEP_PC_ON_FLUSH(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .occupancy_o(occupancy)
    );

    pipe_stage_skid #(.DATA_W(DW), .LANES(LN), .PC_LANE(LANE_PC), .KEEP_PC_ON_FLUSH(1'b0)) dut0 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .in_data_i(in_data), .flush_i(flush), .out_valid_o(out_valid0),
        .out_ready_i(out_ready), .out_data_o(out_data0), .occupancy_o(occupancy0)
    );

    function automatic logic [BW-1:0] mk(input logic [31:0] pc, input logic [31:0] instr);
        logic [BW-1:0] b;
        b = '0;
        b[LANE_ALURES*DW +: DW] = pc + 32'h100;
        b[LANE_HL*DW     +: DW] = pc ^ 32'h0000_00AA;
        b[LANE_PC*DW     +: DW] = pc;
        b[LANE_INSTR*DW  +: DW] = instr;
        b[LANE_FWDRT*DW  +: DW] = ~pc;
        return b;
    endfunction

    function automatic logic [31:0] lane(input logic [BW-1:0] d, input int idx);
        return d[idx*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        in_data = mk(32'h2000, 32'h1);
        #2;
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_occ", BW'(occupancy), BW'(0));
        chk("rst_data", out_data, '0);
        #5 reset = 1'b0; in_valid = 1'b0;

        // Streaming
        in_valid = 1'b1; out_ready = 1'b1; in_data = mk(32'h3000, 32'h11);
        step();
        chk("str0", out_data, mk(32'h3000, 32'h11));
        chk("str0_occ", BW'(occupancy), BW'(1));
        in_data = mk(32'h3004, 32'h12);
        step();
        chk("str1_pc", BW'(lane(out_data, LANE_PC)), BW'(32'h3004));
        chk("str1_occ", BW'(occupancy), BW'(1));
        in_data = mk(32'h3008, 32'h13);
        step();
        chk("str2_pc", BW'(lane(out_data, LANE_PC)), BW'(32'h3008));
        chk("str2_occ", BW'(occupancy), BW'(1));
        in_valid = 1'b0;
        step();
        chk("str_drain_valid", BW'(out_valid), BW'(0));
        chk("str_drain_data", out_data, '0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h3000, 32'h21);
        step();
        chk("bp0_occ", BW'(occupancy), BW'(1));
        in_data = mk(32'h3004, 32'h22);
        step();
        chk("bp1_occ", BW'(occupancy), BW'(2));
        chk("bp1_in_ready", BW'(in_ready), BW'(0));
        chk("bp1_head", out_data, mk(32'h3000, 32'h21));
        in_data = mk(32'h3008, 32'h23);
        step();
        chk("bp2_hold_occ", BW'(occupancy), BW'(2));
        chk("bp2_hold_pc", BW'(lane(out_data, LANE_PC)), BW'(32'h3000));
        out_ready = 1'b1;
        step();
        chk("bp3_pc", BW'(lane(out_data, LANE_PC)), BW'(32'h3004));
        chk("bp3_data", out_data, mk(32'h3004, 32'h22));
        chk("bp3_occ", BW'(occupancy), BW'(1));
        chk("bp3_in_ready", BW'(in_ready), BW'(1));
        step();
        chk("bp4_data", out_data, mk(32'h3008, 32'h23));
        chk("bp4_occ", BW'(occupancy), BW'(1));
        in_valid = 1'b0;
        step();
        chk("bp5_empty", BW'(occupancy), BW'(0));

        // Simultaneous push/pop in ONE
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h3010, 32'h31);
        step();
        chk("pp0_pc", BW'(lane(out_data, LANE_PC)), BW'(32'h3010));
        out_ready = 1'b1; in_data = mk(32'h3014, 32'h32);
        step();
        chk("pp1_data", out_data, mk(32'h3014, 32'h32));
        chk("pp1_occ", BW'(occupancy), BW'(1));
        in_valid = 1'b0;
        step();
        chk("pp2_empty", BW'(out_valid), BW'(0));

        // Flush in TWO
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h3020, 32'h8C820004);
        step();
        in_data = mk(32'h3024, 32'h8C830008);
        step();
        chk("fl_pre_occ", BW'(occupancy), BW'(2));
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", BW'(out_valid), BW'(0));
        chk("fl_occ", BW'(occupancy), BW'(0));
        chk("fl_instr", BW'(lane(out_data, LANE_INSTR)), BW'(0));
        chk("fl_alures", BW'(lane(out_data, LANE_ALURES)), BW'(0));
        chk("fl_pc_keep", BW'(lane(out_data, LANE_PC)), BW'(32'h3020));
        chk("fl_pc_nokeep", out_data0, '0);
        chk("fl_occ_nokeep", BW'(occupancy0), BW'(0));
        out_ready = 1'b1;
        step();
        chk("fl_after_valid", BW'(out_valid), BW'(0));

        // Flush with concurrent push from EMPTY
        in_valid = 1'b1; flush = 1'b1; in_data = mk(32'h3040, 32'h41);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fe_valid", BW'(out_valid), BW'(0));
        chk("fe_occ", BW'(occupancy), BW'(0));
        chk("fe_pc_keep", BW'(lane(out_data, LANE_PC)), BW'(32'h3040));
        chk("fe_instr", BW'(lane(out_data, LANE_INSTR)), BW'(0));
        chk("fe_pc_nokeep", out_data0, '0);
        step();
        chk("fe_not_emitted", BW'(out_valid), BW'(0));

        // Async reset while in TWO
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h3050, 32'h51);
        step();
        in_data = mk(32'h3054, 32'h52);
        step();
        chk("ar_pre_occ", BW'(occupancy), BW'(2));
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", BW'(out_valid), BW'(0));
        chk("ar_data", out_data, '0);
        chk("ar_occ", BW'(occupancy), BW'(0));
        chk("ar_in_ready", BW'(in_ready), BW'(1));
        in_valid = 1'b0;
        #3 reset = 1'b0;
        step();
        chk("ar_after_valid", BW'(out_valid), BW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed five-field EX/MEM pipeline register. It carries LANES packed fields of DATA_W bits between two pipeline stages under a valid/ready handshake. It contains a two-entry skid buffer, so upstream in_ready is registered and breaks the stall combinational path. Flush turns the stage into a bubble and can keep the PC lane so later stages can still produce EPC.

Parameters:
DATA_W, 32, width of each lane
LANES, 5, number of lanes (ALURes, HL, PC, Instr, FWD_rt in the default M-stage use)
PC_LANE, 2, index of the lane holding the PC; must be < LANES
KEEP_PC_ON_FLUSH, 1, 1 = PC lane survives flush; 0 = PC lane zeroed like the other lanes

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat; driven from registered state only
in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
flush  in  1  discard all held beats at the next edge
out_valid  out  1  out_data holds a live beat
out_ready  in  1  downstream accepts the beat
out_data  out  LANES*DATA_W  head entry
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset (async, active-high): state EMPTY, main=0, skid=0, out_valid=0, out_data=0, occupancy=0. While reset is high, in_ready reads 1 but no transfer takes effect.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != TWO). out_valid = (state != EMPTY). out_data = main register. occupancy encodes the state as EMPTY=0, ONE=1, TWO=2.
- Latency: 1 cycle, in_data to out_data, when the stage is empty.
- Transitions, evaluated at each clk edge with flush=0:
  - EMPTY: push -> ONE; main <= in_data.
  - ONE: push & !pop -> TWO; skid <= in_data.
  - ONE: push & pop -> ONE; main <= in_data.
  - ONE: !push & pop -> EMPTY; main <= 0.
  - ONE: otherwise, hold.
  - TWO: pop -> ONE; main <= skid; skid <= 0. push cannot occur because in_ready=0.
  - TWO: !pop -> hold.
- Order: beats leave in acceptance order. No beat is duplicated or lost except by flush.
- Flush: from any state, next state is EMPTY and skid <= 0.
  - main <= 0, except PC lane when KEEP_PC_ON_FLUSH=1: it keeps main's current PC lane, or takes in_data's PC lane if the state was EMPTY and push was occurring.
  - A beat pushed in the flush cycle is discarded.
  - Flush has priority over pop. A pop in the flush cycle still counts as delivered, since downstream sampled it.
- When EMPTY, out_data is 0 apart from a possibly retained PC lane. Instr=0 therefore decodes as nop downstream.
- Back-to-back throughput: with out_ready held at 1, one beat per cycle and the skid is never used.
- Reset asserted mid-transfer: all held beats are lost and outputs go to reset values immediately, without waiting for clk.

Decomposition:
- Shared package pipe_pkg holds:
  - state typedef {EMPTY, ONE, TWO}
  - lane-index constants for the M stage: LANE_ALURES=0, LANE_HL=1, LANE_PC=2, LANE_INSTR=3, LANE_FWDRT=4
- One sub-module, pipe_slot: a LANES*DATA_W register with async reset, load enable, and clear with PC-lane keep mask. It is instantiated twice, as main and skid.

Test Plan:
- Reset mid-stream while in TWO -> out_valid=0, out_data=0 and occupancy=0 before the next clk edge; in_ready=1.
- Streaming: in_valid=1, out_ready=1, PCs 0x3000, 0x3004, 0x3008 on consecutive cycles -> out_data PC lanes show the same sequence, each one cycle later; occupancy stays at 1.
- Backpressure: out_ready=0, push PC=0x3000 then 0x3004 -> occupancy=2 and in_ready=0. A third beat at 0x3008 is held off upstream. Raising out_ready drains 0x3000, then 0x3004, then 0x3008 in that order.
- Simultaneous push/pop in ONE: main PC=0x3010, push 0x3014 with out_ready=1 -> next cycle out_data PC=0x3014 and occupancy=1.
- Flush in TWO, main PC=0x3020 and Instr=0x8C820004 -> next cycle out_valid=0, occupancy=0, Instr lane=0. PC lane=0x3020 with KEEP_PC_ON_FLUSH=1, or 0 with KEEP_PC_ON_FLUSH=0.
- Flush with concurrent push from EMPTY, in PC=0x3040 -> stays EMPTY and the beat is not emitted; PC lane=0x3040 with KEEP_PC_ON_FLUSH=1.
